thread_register_file: RTL and testbench
=======================================

Name: thread_register_file

Overview:
- Per-thread 16-entry x DATA_BITS register file feeding `rs`/`rt` to the integer ALU and the FMA unit.
- Captures write-back from the ALU, the LSU load path, decoded immediates, or the FMA result.
- Sits directly upstream of the ALU (operand source) and downstream of it (`alu_out` write-back).
- R13..R15 are read-only special registers: blockIdx, blockDim, threadIdx.

Parameters:
- THREADS_PER_BLOCK, 4, threads per block; sets the threadIdx constant and the blockDim value.
- THREAD_ID, 0, index of this thread within its core; loaded into R15.
- DATA_BITS, 16, register width.

Ports:
- clk  input  1  core clock.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- enable  input  1  thread active in current block; when 0, no state changes.
- block_id  input  DATA_BITS  current block index from dispatcher.
- core_state  input  3  IDLE=000 FETCH=001 DECODE=010 REQUEST=011 WAIT=100 EXECUTE=101 UPDATE=110 DONE=111.
- decoded_rd_address  input  4  destination register.
- decoded_rs_address  input  4  source 1.
- decoded_rt_address  input  4  source 2.
- decoded_reg_write_enable  input  1  instruction writes rd.
- decoded_reg_input_mux  input  2  0=ALU, 1=MEMORY, 2=CONSTANT, 3=FMA.
- decoded_immediate  input  8  immediate for CONSTANT.
- alu_out  input  DATA_BITS  ALU result.
- lsu_out  input  DATA_BITS  load data.
- fma_out  input  DATA_BITS  Q1.15 FMA result.
- rs  output  DATA_BITS  registered operand 1.
- rt  output  DATA_BITS  registered operand 2.

Behaviour:
- Reset (reset==0, async):
  - R0..R12 = 0; `rs` = 0; `rt` = 0.
  - R13 = 0; R14 = THREADS_PER_BLOCK; R15 = THREAD_ID.
- All non-reset updates occur on posedge clk and only when enable==1. With enable==0 every register and output holds.
- R13 capture:
  - R13 <= block_id every cycle core_state==IDLE.
  - R13 holds in every other state, so a block_id change mid-block is ignored.
- Operand read, core_state==REQUEST:
  - rs <= R[decoded_rs_address]; rt <= R[decoded_rt_address].
  - Latency: operands are valid one cycle after entering REQUEST and stay stable through WAIT/EXECUTE/UPDATE until the next REQUEST.
- Write-back, core_state==UPDATE and decoded_reg_write_enable==1 and decoded_rd_address<13:
  - mux 0: R[rd] <= alu_out.
  - mux 1: R[rd] <= lsu_out.
  - mux 2: R[rd] <= zero-extended decoded_immediate (upper DATA_BITS-8 bits = 0).
  - mux 3: R[rd] <= fma_out.
- Writes to rd 13..15 are silently dropped; special registers are unchanged.
- Read and write never share a cycle, because REQUEST and UPDATE are distinct states. No bypass is required.
- A read of R[rd] in the next instruction's REQUEST returns the value written in the previous UPDATE.
- FETCH, DECODE, WAIT, EXECUTE, DONE: no register or output changes.
- Reset asserted mid-instruction (e.g. during UPDATE): the pending write is lost and reset values apply immediately.
- On deassertion, resume normal behaviour at the next posedge.
- R0 is a normal writable register; it is not hardwired to zero.

Test Plan:
- Reset then read → R15 = THREAD_ID.
  - Stimulus: THREAD_ID=2, THREADS_PER_BLOCK=4. Pulse reset low; then REQUEST with rs_addr=15, rt_addr=14.
  - Response: rs=2, rt=4. R0..R12 read 0.
- CONSTANT write-back to R3.
  - Stimulus: IDLE with block_id=7. UPDATE, mux=2, imm=0xA5, rd=3, we=1. Then REQUEST rs=3, rt=13.
  - Response: rs=0x00A5, rt=7.
- Write-back source select to R1 and R2.
  - Stimulus: alu_out=0x1234 with mux=0 to R1; lsu_out=0xBEEF with mux=1 to R2; then read R1/R2.
  - Response: 0x1234 and 0xBEEF.
  - Repeat with fma_out=0x4000, mux=3 → 0x4000.
- Protected and disabled writes are dropped.
  - Stimulus: UPDATE with rd=14, we=1, alu_out=0xFFFF.
  - Response: R14 still reads 4.
  - Stimulus: UPDATE with rd=5, we=0, then with we=1 and enable=0.
  - Response: R5 stays 0 in both cases.
- Mid-operation reset clears pending state.
  - Stimulus: R6=0x0055; during UPDATE to R6 with alu_out=0x1111, assert reset asynchronously between edges.
  - Response: rs, rt, and R6 read 0 immediately, with no clock edge. After release, REQUEST rs=6 → 0.
- R13 ignores block_id outside IDLE.
  - Stimulus: change block_id 3→9 while core_state=EXECUTE.
  - Response: R13 keeps its IDLE-captured value 3, and updates to 9 only after returning to IDLE.

Source files
------------

// File: rtl/thread_register_file_if.sv
// thread_register_file_if: decode/write-back/operand bundle between core control and a thread's register file
interface thread_register_file_if #(parameter int DATA_BITS = 16);
  logic                 enable;
  logic [DATA_BITS-1:0] block_id;
  logic [2:0]           core_state;
  logic [3:0]           decoded_rd_address;
  logic [3:0]           decoded_rs_address;
  logic [3:0]           decoded_rt_address;
  logic                 decoded_reg_write_enable;
  logic [1:0]           decoded_reg_input_mux;
  logic [7:0]           decoded_immediate;
  logic [DATA_BITS-1:0] alu_out;
  logic [DATA_BITS-1:0] lsu_out;
  logic [DATA_BITS-1:0] fma_out;
  logic [DATA_BITS-1:0] rs;
  logic [DATA_BITS-1:0] rt;
  modport master (
    output enable, block_id, core_state, decoded_rd_address, decoded_rs_address,
           decoded_rt_address, decoded_reg_write_enable, decoded_reg_input_mux,
           decoded_immediate, alu_out, lsu_out, fma_out,
    input  rs, rt
  );
  modport slave (
    input  enable, block_id, core_state, decoded_rd_address, decoded_rs_address,
           decoded_rt_address, decoded_reg_write_enable, decoded_reg_input_mux,
           decoded_immediate, alu_out, lsu_out, fma_out,
    output rs, rt
  );
endinterface

// File: rtl/thread_register_file.sv
// thread_register_file: per-thread 16-entry register file; R13..R15 hold blockIdx, blockDim, threadIdx
module thread_register_file #(
  parameter int THREADS_PER_BLOCK = 4,
  parameter int THREAD_ID         = 0,
  parameter int DATA_BITS         = 16
) (
  input logic clk,
  input logic reset,
  thread_register_file_if.slave bus
);
  localparam logic [2:0] IDLE = 3'b000, REQUEST = 3'b011, UPDATE = 3'b110;
  logic [DATA_BITS-1:0] regs [16];
  logic [DATA_BITS-1:0] rs_q, rt_q, wb_data;
  logic                 wb_en;
  always_comb begin
    wb_data = bus.decoded_reg_input_mux == 2'd0 ? bus.alu_out :
              bus.decoded_reg_input_mux == 2'd1 ? bus.lsu_out :
              bus.decoded_reg_input_mux == 2'd2 ? DATA_BITS'(bus.decoded_immediate) : bus.fma_out;
    wb_en   = bus.core_state == UPDATE && bus.decoded_reg_write_enable && bus.decoded_rd_address < 4'd13;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 14; i++) regs[i] <= '0;
      regs[14] <= DATA_BITS'(THREADS_PER_BLOCK);
      regs[15] <= DATA_BITS'(THREAD_ID);
      rs_q     <= '0;
      rt_q     <= '0;
    end else if (bus.enable) begin
      if (bus.core_state == IDLE) regs[13] <= bus.block_id;
      if (bus.core_state == REQUEST) begin
        rs_q <= regs[bus.decoded_rs_address];
        rt_q <= regs[bus.decoded_rt_address];
      end
      if (wb_en) regs[bus.decoded_rd_address] <= wb_data;
    end
  end
  assign bus.rs = rs_q;
  assign bus.rt = rt_q;
endmodule

// File: tb/tb_thread_register_file.sv
// tb_thread_register_file: directed vectors against hand-computed register contents
module tb_thread_register_file;
  localparam logic [2:0] IDLE = 3'b000, FETCH = 3'b001, EXECUTE = 3'b101, REQUEST = 3'b011, UPDATE = 3'b110, DONE = 3'b111;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;
  thread_register_file_if #(.DATA_BITS(16)) bus ();
  thread_register_file #(.THREADS_PER_BLOCK(4), .THREAD_ID(2), .DATA_BITS(16)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step(input logic [2:0] st);
    bus.core_state = st;
    @(posedge clk);
    #1;
  endtask
  task automatic read(input logic [3:0] a, input logic [3:0] b);
    bus.decoded_rs_address = a;
    bus.decoded_rt_address = b;
    step(REQUEST);
  endtask
  task automatic write(input logic [3:0] rd, input logic [1:0] mux, input logic we, input logic [15:0] val);
    bus.decoded_rd_address       = rd;
    bus.decoded_reg_input_mux    = mux;
    bus.decoded_reg_write_enable = we;
    bus.decoded_immediate        = val[7:0];
    bus.alu_out = mux == 2'd0 ? val : 16'hDEAD;
    bus.lsu_out = mux == 2'd1 ? val : 16'hDEAD;
    bus.fma_out = mux == 2'd3 ? val : 16'hDEAD;
    step(UPDATE);
    bus.decoded_reg_write_enable = 1'b0;
  endtask
  initial begin
    bus.enable = 1'b1;
    bus.block_id = 16'd0;
    bus.core_state = IDLE;
    bus.decoded_rd_address = 4'd0;
    bus.decoded_rs_address = 4'd0;
    bus.decoded_rt_address = 4'd0;
    bus.decoded_reg_write_enable = 1'b0;
    bus.decoded_reg_input_mux = 2'd0;
    bus.decoded_immediate = 8'd0;
    bus.alu_out = 16'd0;
    bus.lsu_out = 16'd0;
    bus.fma_out = 16'd0;
    #22;
    check("reset_rs", bus.rs, 16'h0000);
    check("reset_rt", bus.rt, 16'h0000);
    reset = 1'b1;
    @(posedge clk);
    #1;
    bus.block_id = 16'd7;
    step(FETCH);
    read(4'd15, 4'd14);
    check("r15_thread_id", bus.rs, 16'd2);
    check("r14_block_dim", bus.rt, 16'd4);
    for (int i = 0; i < 13; i++) begin
      read(4'(i), 4'(12 - i));
      check($sformatf("reset_r%0d", i), bus.rs, 16'h0000);
    end
    step(IDLE);
    write(4'd3, 2'd2, 1'b1, 16'h00A5);
    read(4'd3, 4'd13);
    check("const_r3", bus.rs, 16'h00A5);
    check("r13_block_id", bus.rt, 16'd7);
    write(4'd1, 2'd0, 1'b1, 16'h1234);
    write(4'd2, 2'd1, 1'b1, 16'hBEEF);
    read(4'd1, 4'd2);
    check("alu_r1", bus.rs, 16'h1234);
    check("lsu_r2", bus.rt, 16'hBEEF);
    write(4'd4, 2'd3, 1'b1, 16'h4000);
    read(4'd4, 4'd3);
    check("fma_r4", bus.rs, 16'h4000);
    check("r3_kept", bus.rt, 16'h00A5);
    bus.decoded_rs_address = 4'd1;
    step(DONE);
    step(EXECUTE);
    check("hold_outside_request", bus.rs, 16'h4000);
    write(4'd14, 2'd0, 1'b1, 16'hFFFF);
    write(4'd15, 2'd0, 1'b1, 16'hFFFF);
    read(4'd14, 4'd15);
    check("r14_protected", bus.rs, 16'd4);
    check("r15_protected", bus.rt, 16'd2);
    write(4'd5, 2'd0, 1'b0, 16'h7777);
    read(4'd5, 4'd0);
    check("we0_r5", bus.rs, 16'h0000);
    bus.enable = 1'b0;
    write(4'd5, 2'd0, 1'b1, 16'h7777);
    read(4'd1, 4'd2);
    check("disabled_read_rs_hold", bus.rs, 16'h0000);
    bus.enable = 1'b1;
    read(4'd5, 4'd1);
    check("disabled_r5", bus.rs, 16'h0000);
    check("r1_after_disable", bus.rt, 16'h1234);
    write(4'd6, 2'd2, 1'b1, 16'h0055);
    read(4'd6, 4'd6);
    check("r6_before_reset", bus.rs, 16'h0055);
    bus.decoded_rd_address = 4'd6;
    bus.decoded_reg_input_mux = 2'd0;
    bus.decoded_reg_write_enable = 1'b1;
    bus.alu_out = 16'h1111;
    bus.core_state = UPDATE;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("async_rs", bus.rs, 16'h0000);
    check("async_rt", bus.rt, 16'h0000);
    @(posedge clk);
    #1;
    reset = 1'b1;
    bus.decoded_reg_write_enable = 1'b0;
    read(4'd6, 4'd15);
    check("r6_after_reset", bus.rs, 16'h0000);
    check("r15_after_reset", bus.rt, 16'd2);
    bus.block_id = 16'd3;
    step(IDLE);
    step(EXECUTE);
    bus.block_id = 16'd9;
    step(EXECUTE);
    step(UPDATE);
    read(4'd13, 4'd13);
    check("r13_hold", bus.rs, 16'd3);
    step(IDLE);
    read(4'd13, 4'd14);
    check("r13_recapture", bus.rs, 16'd9);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
